layer_sequencer: RTL and testbench
==================================

// Module: layer_sequencer
// PURPOSE
//  Sequences one fully-connected NN layer over the shared address generator (AG) and MAC ALU.
//  Per neuron: clear the ALU, stream N_INPUTS weight/input reads, drain the MAC pipe, then write one result.
//  Sits between the top-level start/done handshake and the AG/ALU datapath.
// PARAMETERS
//  N_INPUTS     4  inputs per neuron (>=1)
//  N_NEURONS    3  neurons per layer (>=1)
//  MAC_LATENCY  2  ALU cycles from last ALU_en to valid accumulator (>=0)
// PORTS
//  clk       in   1     clock, rising edge
//  reset     in   1     asynchronous, active-low reset
//  start     in   1     begin layer; sampled only in IDLE
//  busy      out  1     high in every state except IDLE
//  done      out  1     one-cycle pulse when the layer is complete
//  AG_rst    out  1     AG reset to address 0
//  AG_read   out  1     AG read strobe / address advance
//  ALU_rst   out  1     clears the MAC accumulator
//  ALU_en    out  1     MAC accumulate enable (AG_read delayed 1 cycle for memory latency)
//  out_we    out  1     result write strobe
//  out_addr  out  NW    neuron index, NW = max(1,$clog2(N_NEURONS))
// BEHAVIOUR
//  Reset (reset=0, immediate): state=IDLE, counters=0; AG_rst=1, ALU_rst=1; all other outputs 0.
//  IDLE:  AG_rst=1, ALU_rst=1; start=1 -> CLR, neuron=0.
//  CLR:   1 cycle; ALU_rst=1; AG_rst=1 only when neuron==0 (AG runs continuously across neurons) -> ACCUM.
//  ACCUM: exactly N_INPUTS cycles with AG_read=1; input counter wraps to 0 on exit -> DRAIN.
//  DRAIN: MAC_LATENCY+1 cycles; first cycle carries the final ALU_en pulse -> WRITE.
//  WRITE: 1 cycle; out_we=1, out_addr=neuron.
//         neuron==N_NEURONS-1 -> DONE; else neuron+1 -> CLR.
//  DONE:  1 cycle; done=1, busy=1 -> IDLE.
//  ALU_en: registered copy of AG_read; it is 0 on the cycle after reset.
//  Latency: done is high exactly N_NEURONS*(N_INPUTS+MAC_LATENCY+3)+1 cycles after the edge that samples start
//           (28 at default parameters).
//  Boundaries:
//   - start outside IDLE is ignored; no queuing.
//   - start held high re-arms only after returning to IDLE.
//   - reset asserted mid-layer aborts at once with no partial write; the next start runs a full layer.
//   - N_NEURONS=1: WRITE goes straight to DONE.
//   - MAC_LATENCY=0: DRAIN is 1 cycle.
//  Outputs are registered, or decoded only from registered state; no combinational path from start.
// CONFIGURATION
//  LAYER_SEQ_BIAS_EN defined:
//   - adds output port bias_load (1 bit) and a 1-cycle BIAS state between CLR and ACCUM with bias_load=1.
//   - per-neuron cost becomes N_INPUTS+MAC_LATENCY+4.
//  LAYER_SEQ_BIAS_EN undefined: no bias_load port, no BIAS state; timing as above.
// STRUCTURE
//  Package layer_seq_pkg:
//   - state encoding constants IDLE/CLR/BIAS/ACCUM/DRAIN/WRITE/DONE (3-bit, BIAS code reserved when unused).
//   - counter-width helper function.
//  Sub-module seq_counter:
//   - parameterised load/enable counter with terminal-count flag.
//   - instantiated for the input, drain and neuron counters.
// TESTING
//  1. Defaults, 1-cycle start -> AG_rst pulses once, AG_read 4 consecutive cycles x3,
//     out_we with out_addr 0,1,2, done at cycle 28.
//  2. start pulsed again during ACCUM of neuron 1 -> ignored; exactly 3 writes, a single done at cycle 28.
//  3. reset low during ACCUM of neuron 2 -> outputs at reset values in the same cycle, no out_we;
//     next start gives done at 28.
//  4. N_INPUTS=1, N_NEURONS=1, MAC_LATENCY=0 -> AG_read 1 cycle, out_we addr 0, done at cycle 5.
//  5. LAYER_SEQ_BIAS_EN defined, defaults -> bias_load one cycle after each CLR, done at cycle 31.
//  6. start held high -> done, then IDLE for 1 cycle, then a new CLR with AG_rst=1; the layer repeats.

Source files
------------

// File: rtl/layer_seq_pkg.sv
// Shared types and helpers for the layer sequencer.
// Defines the state encoding and the counter-width helper.
package layer_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    BIAS  = 3'd2,
    ACCUM = 3'd3,
    DRAIN = 3'd4,
    WRITE = 3'd5,
    DONE  = 3'd6
  } state_e;

  // Width needed to hold 0..n-1, at least 1 bit.
  function automatic int unsigned cnt_w(
    input int unsigned n
  );
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/layer_sequencer_counter.sv
// seq_counter: clear/enable counter, wraps at MAX, tc high at MAX.
// Ports: clk, reset (async low), clr, en, cnt[WIDTH], tc.
module seq_counter #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned MAX   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == MAX_V) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == MAX_V);

endmodule

// File: rtl/layer_sequencer.sv
// Sequences one FC layer over the AG and MAC ALU (start/busy/done).
// Ports: AG_rst/AG_read, ALU_rst/ALU_en, out_we/out_addr; bias_load with LAYER_SEQ_BIAS_EN.
module layer_sequencer
  import layer_seq_pkg::*;
#(
  parameter int unsigned N_INPUTS    = 4,
  parameter int unsigned N_NEURONS   = 3,
  parameter int unsigned MAC_LATENCY = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  output logic AG_rst,
  output logic AG_read,
  output logic ALU_rst,
  output logic ALU_en,
  output logic out_we,
  output logic [cnt_w(N_NEURONS)-1:0] out_addr
`ifdef LAYER_SEQ_BIAS_EN
  ,
  output logic bias_load
`endif
);

  localparam int unsigned IW = cnt_w(N_INPUTS);
  localparam int unsigned DW = cnt_w(MAC_LATENCY + 1);
  localparam int unsigned NW = cnt_w(N_NEURONS);

  state_e state_q;
  state_e state_d;
  logic   alu_en_q;
  logic   alu_en_d;

  logic          is_idle;
  logic          is_accum;
  logic          is_drain;
  logic          is_write;
  logic          in_tc;
  logic          dr_tc;
  logic          nr_tc;
  logic [IW-1:0] in_cnt_unused;
  logic [DW-1:0] dr_cnt_unused;
  logic [NW-1:0] nr_cnt;

  assign is_idle  = (state_q == IDLE);
  assign is_accum = (state_q == ACCUM);
  assign is_drain = (state_q == DRAIN);
  assign is_write = (state_q == WRITE);

  seq_counter #(
    .WIDTH(IW),
    .MAX  (N_INPUTS - 1)
  ) u_in_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (is_idle),
    .en   (is_accum),
    .cnt  (in_cnt_unused),
    .tc   (in_tc)
  );

  seq_counter #(
    .WIDTH(DW),
    .MAX  (MAC_LATENCY)
  ) u_dr_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (is_idle),
    .en   (is_drain),
    .cnt  (dr_cnt_unused),
    .tc   (dr_tc)
  );

  seq_counter #(
    .WIDTH(NW),
    .MAX  (N_NEURONS - 1)
  ) u_nr_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (is_idle),
    .en   (is_write),
    .cnt  (nr_cnt),
    .tc   (nr_tc)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLR;
        end
      end
`ifdef LAYER_SEQ_BIAS_EN
      CLR:   state_d = BIAS;
      BIAS:  state_d = ACCUM;
`else
      CLR:   state_d = ACCUM;
`endif
      ACCUM: begin
        if (in_tc) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (dr_tc) begin
          state_d = WRITE;
        end
      end
      WRITE: state_d = nr_tc ? DONE : CLR;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ALU_en trails AG_read by one cycle for memory latency.
  assign alu_en_d = is_accum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      alu_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      alu_en_q <= alu_en_d;
    end
  end

  // AG keeps running across neurons; only rewind it at neuron 0.
  assign AG_rst   = is_idle
                  | ((state_q == CLR) & (nr_cnt == '0));
  assign ALU_rst  = is_idle | (state_q == CLR);
  assign AG_read  = is_accum;
  assign ALU_en   = alu_en_q;
  assign out_we   = is_write;
  assign out_addr = is_write ? nr_cnt : '0;
  assign done     = (state_q == DONE);
  assign busy     = !is_idle;
`ifdef LAYER_SEQ_BIAS_EN
  assign bias_load = (state_q == BIAS);
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer with an event scoreboard.
// Covers default and minimal parameter sets; LAYER_SEQ_BIAS_EN aware.
module tb_layer_sequencer;

  localparam int NI = 4;
  localparam int NN = 3;
  localparam int ML = 2;
`ifdef LAYER_SEQ_BIAS_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int P  = NI + ML + 3 + EXTRA;
  localparam int P2 = 1 + 0 + 3 + EXTRA;

  typedef struct {
    int dut;
    int kind;
    int addr;
    int cyc;
  } ev_t;

  ev_t sb[$];

  logic clk;
  logic reset;
  logic start;
  logic start2;

  logic       busy, done, ag_rst, ag_read;
  logic       alu_rst, alu_en, out_we;
  logic [1:0] out_addr;
  logic       busy2, done2, ag_rst2, ag_read2;
  logic       alu_rst2, alu_en2, out_we2;
  logic [0:0] out_addr2;
`ifdef LAYER_SEQ_BIAS_EN
  logic       bias_load, bias_load2;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int s        = 0;
  int rl       = 0;
  int rl2      = 0;
  int clr_idx  = 0;
  logic prev_read  = 1'b0;
  logic prev_read2 = 1'b0;
  logic prev_clr   = 1'b0;

  layer_sequencer #(
    .N_INPUTS   (NI),
    .N_NEURONS  (NN),
    .MAC_LATENCY(ML)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .AG_rst  (ag_rst),
    .AG_read (ag_read),
    .ALU_rst (alu_rst),
    .ALU_en  (alu_en),
    .out_we  (out_we),
    .out_addr(out_addr)
`ifdef LAYER_SEQ_BIAS_EN
    ,
    .bias_load(bias_load)
`endif
  );

  layer_sequencer #(
    .N_INPUTS   (1),
    .N_NEURONS  (1),
    .MAC_LATENCY(0)
  ) dut2 (
    .clk     (clk),
    .reset   (reset),
    .start   (start2),
    .busy    (busy2),
    .done    (done2),
    .AG_rst  (ag_rst2),
    .AG_read (ag_read2),
    .ALU_rst (alu_rst2),
    .ALU_en  (alu_en2),
    .out_we  (out_we2),
    .out_addr(out_addr2)
`ifdef LAYER_SEQ_BIAS_EN
    ,
    .bias_load(bias_load2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic push_layer(
    input int dut_id,
    input int s0,
    input int nn,
    input int p
  );
    for (int k = 0; k < nn; k++) begin
      sb.push_back('{dut_id, 0, k, s0 + (k + 1) * p - 1});
    end
    sb.push_back('{dut_id, 1, 0, s0 + nn * p});
  endtask

  task automatic got_ev(
    input int dut_id,
    input int kind,
    input int addr
  );
    ev_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
    end else begin
      e = '{-1, -1, -1, -1};
    end
    check("ev_dut", dut_id, e.dut);
    check("ev_kind", kind, e.kind);
    check("ev_addr", addr, e.addr);
    check("ev_cycle", cyc, e.cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    check("alu_en", alu_en, prev_read);
    check("alu_en2", alu_en2, prev_read2);
    prev_read  = ag_read;
    prev_read2 = ag_read2;
    if (ag_read) begin
      rl++;
    end else if (rl != 0) begin
      check("ag_read_run", rl, NI);
      rl = 0;
    end
    if (ag_read2) begin
      rl2++;
    end else if (rl2 != 0) begin
      check("ag_read_run2", rl2, 1);
      rl2 = 0;
    end
    if (alu_rst && busy) begin
      check("ag_rst_clr", ag_rst, (clr_idx % NN) == 0);
      clr_idx++;
    end else if (busy) begin
      check("ag_rst_busy", ag_rst, 0);
    end
`ifdef LAYER_SEQ_BIAS_EN
    check("bias_load", bias_load, prev_clr);
`endif
    prev_clr = alu_rst && busy;
    if (out_we)  got_ev(0, 0, out_addr);
    if (done)    got_ev(0, 1, 0);
    if (out_we2) got_ev(1, 0, out_addr2);
    if (done2)   got_ev(1, 1, 0);
  endtask

  task automatic launch(input int dut_id);
    s = cyc + 1;
    if (dut_id == 0) begin
      clr_idx = 0;
      push_layer(0, s, NN, P);
      start = 1'b1;
      tick();
      start = 1'b0;
    end else begin
      push_layer(1, s, 1, P2);
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
    end
  endtask

  task automatic drain_sb(input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    check("sb_drained", sb.size(), 0);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ag_rst"}, ag_rst, 1);
    check({tag, "_alu_rst"}, alu_rst, 1);
    check({tag, "_ag_read"}, ag_read, 0);
    check({tag, "_alu_en"}, alu_en, 0);
    check({tag, "_out_we"}, out_we, 0);
    check({tag, "_out_addr"}, out_addr, 0);
    check({tag, "_busy2"}, busy2, 0);
    check({tag, "_ag_rst2"}, ag_rst2, 1);
    check({tag, "_alu_rst2"}, alu_rst2, 1);
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
    end
  endtask

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    #1;
    check_reset_outs("rst");
    idle_ticks(2);
    reset = 1'b1;
    idle_ticks(2);
    check("idle_busy", busy, 0);

    // single layer, default parameters
    launch(0);
    check("t1_busy", busy, 1);
    drain_sb(60);
    idle_ticks(3);
    check("t1_idle", busy, 0);

    // start pulsed during ACCUM of neuron 1
    launch(0);
    while (cyc < s + 10) tick();
    check("t2_accum", ag_read, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    drain_sb(60);
    idle_ticks(6);

    // reset during ACCUM of neuron 2
    launch(0);
    while (cyc < s + 20) tick();
    check("t3_accum", ag_read, 1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outs("abort");
    sb.delete();
    prev_read = 1'b0;
    rl        = 0;
    clr_idx   = 0;
    idle_ticks(2);
    reset = 1'b1;
    idle_ticks(4);
    launch(0);
    drain_sb(60);
    idle_ticks(2);

    // minimal parameter instance
    launch(1);
    check("t4_busy2", busy2, 1);
    drain_sb(20);
    idle_ticks(2);
    check("t4_idle2", busy2, 0);

    // start held high: layer repeats after one IDLE cycle
    s = cyc + 1;
    clr_idx = 0;
    push_layer(0, s, NN, P);
    push_layer(0, s + NN * P + 2, NN, P);
    start = 1'b1;
    while (cyc < s + NN * P + 1) tick();
    check("t6_idle_gap", busy, 0);
    tick();
    check("t6_reclr_ag_rst", ag_rst, 1);
    check("t6_reclr_busy", busy, 1);
    start = 1'b0;
    drain_sb(80);
    idle_ticks(4);
    check("t6_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
